// File: rtl/req_wb_bridge_pkg.sv
// Shared types for the core-request to Wishbone classic bridge.
// Holds the bridge FSM state encoding used by the top level.
package req_wb_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } bridge_state_t;

endpackage

// File: rtl/wb_timeout_counter.sv
// Counts stb cycles of one Wishbone access; flags the cycle in which the count reaches TIMEOUT_CYCLES.
// Latency: expired_o is combinational from the count; no backpressure, TIMEOUT_CYCLES = 0 disables it.
module wb_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic sys_clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_off
         logic unused_inputs;
         assign unused_inputs = ^{sys_clk, rst_n, clear_i, enable_i};
         assign expired_o     = 1'b0;
      end else begin : g_on
         localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
         logic [CW-1:0] cnt;
         logic [CW-1:0] cnt_nxt;

         assign cnt_nxt = cnt + 1'b1;

         always_ff @(posedge sys_clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt <= '0;
            end else if (clear_i) begin
               cnt <= '0;
            end else if (enable_i) begin
               cnt <= cnt_nxt;
            end
         end

         // Fires in the stb cycle whose closing edge brings the count to the limit,
         // so the access is aborted after exactly TIMEOUT_CYCLES stb cycles.
         assign expired_o = enable_i && (cnt_nxt == CW'(TIMEOUT_CYCLES));
      end
   endgenerate

endmodule

// File: rtl/req_wb_bridge.sv
// Bridges a split read/write request port onto one Wishbone classic master; write wins on contention.
// Latency: response 2 cycles after the request edge with a zero-wait slave; requests are level and only sampled in IDLE.
module req_wb_bridge
   import req_wb_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int ERR_CNT_WIDTH  = 16
) (
   input  logic                     sys_clk,
   input  logic                     rst_n,
   input  logic [ADDR_WIDTH-1:0]    rw_address_i,
   input  logic [DATA_WIDTH-1:0]    write_data_i,
   input  logic [DATA_WIDTH/8-1:0]  write_strobe_i,
   input  logic                     read_request_i,
   input  logic                     write_request_i,
   output logic [DATA_WIDTH-1:0]    read_data_o,
   output logic                     read_response_o,
   output logic                     write_response_o,
   output logic                     bus_error_o,
   output logic [ERR_CNT_WIDTH-1:0] err_count_o,
   output logic                     wb_cyc_o,
   output logic                     wb_stb_o,
   output logic                     wb_we_o,
   output logic [ADDR_WIDTH-1:0]    wb_addr_o,
   output logic [DATA_WIDTH-1:0]    wb_data_o,
   output logic [DATA_WIDTH/8-1:0]  wb_sel_o,
   input  logic [DATA_WIDTH-1:0]    wb_data_i,
   input  logic                     wb_ack_i,
   input  logic                     wb_err_i
);

   bridge_state_t state;
   bridge_state_t state_nxt;
   logic          accept;
   logic          done;
   logic          fail;
   logic          expired;
   logic          err_flag;

   assign accept = (state == IDLE) && (read_request_i || write_request_i);
   assign done   = (state == BUS) && (wb_ack_i || wb_err_i || expired);
   // A slave ack landing in the expiry cycle still counts as a good completion.
   assign fail   = wb_err_i || (expired && !wb_ack_i);

   wb_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .clear_i   (state != BUS),
      .enable_i  (state == BUS),
      .expired_o (expired)
   );

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt        = state;
      read_response_o  = 1'b0;
      write_response_o = 1'b0;
      bus_error_o      = 1'b0;
      case (state)
         IDLE: if (accept) state_nxt = BUS;
         BUS:  if (done)   state_nxt = RESP;
         RESP: begin
            state_nxt        = IDLE;
            read_response_o  = !wb_we_o;
            write_response_o = wb_we_o;
            bus_error_o      = err_flag;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // wb_we_o doubles as the latched direction of the access in flight.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_cyc_o    <= 1'b0;
         wb_stb_o    <= 1'b0;
         wb_we_o     <= 1'b0;
         wb_addr_o   <= '0;
         wb_data_o   <= '0;
         wb_sel_o    <= '0;
         err_flag    <= 1'b0;
         read_data_o <= '0;
         err_count_o <= '0;
      end else begin
         if (accept) begin
            wb_cyc_o  <= 1'b1;
            wb_stb_o  <= 1'b1;
            wb_we_o   <= write_request_i;
            wb_addr_o <= rw_address_i;
            wb_data_o <= write_data_i;
            wb_sel_o  <= write_request_i ? write_strobe_i : '1;
         end
         if (done) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            err_flag <= fail;
            if (!wb_we_o) begin
               read_data_o <= fail ? '0 : wb_data_i;
            end
            if (fail && (err_count_o != '1)) begin
               err_count_o <= err_count_o + 1'b1;
            end
         end
      end
   end

endmodule
